pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the 16-bit vector ASIP pipeline. It drives the PC write enable and redirect target into the fetch stage, and the enable/flush controls of the fetch→decode and decode→execute pipe registers. It resolves load-use stalls and taken-branch flushes. It sequences multi-lane vector instructions by holding them in decode while issuing one lane per cycle to execute.

## Interface
- LANES, 4: vector lanes per vector instruction; power of two, 2..16.
- REG_W, 4: register-address width.
- PC_W, 8: program-counter / branch-target width.
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- instr_valid_d  in  1  decode stage holds a valid instruction
- is_vec_d  in  1  decode instruction is a vector op
- rs1_d, rs2_d  in  REG_W  decode source registers
- uses_rs1_d, uses_rs2_d  in  1  corresponding source is read
- mem_read_e  in  1  execute instruction is a load
- reg_write_e  in  1  execute instruction writes a register
- rd_e  in  REG_W  execute destination register
- branch_taken_e  in  1  execute resolved a taken branch
- branch_target_e  in  PC_W  target of that branch
- pcWrEn  out  1  PC updates this cycle
- pc_sel  out  1  1: PC loads newPc; 0: PC increments
- newPc  out  PC_W  redirect target; branch_target_e when pc_sel=1, else 0
- fd_en, de_en  out  1  fetch→decode / decode→execute pipe load enables
- fd_flush, de_flush  out  1  load a NOP into the respective pipe register (wins over enable)
- vec_lane  out  $clog2(LANES)  lane index issued to execute this cycle
- vec_active  out  1  a vector lane is being issued this cycle
- stall_cycles  out  16  saturating count of cycles with pcWrEn=0 outside reset

## Operation
- Registered state: mode {RUN, VEC}, lane counter cnt, stall_cycles. All other outputs are combinational from the state and the inputs.
- Default in RUN (no event): pcWrEn=1, fd_en=1, de_en=1, flushes 0, pc_sel=0, vec_active=0, vec_lane=0.
- Load-use hazard: `hz = instr_valid_d & mem_read_e & reg_write_e & ((uses_rs1_d & rs1_d==rd_e) | (uses_rs2_d & rs2_d==rd_e))`. Register 0 is not special.
  - While hz: pcWrEn=0, fd_en=0, de_flush=1 (bubble into execute).
  - Lasts exactly while hz holds (normally 1 cycle).
- Vector start: in RUN with instr_valid_d & is_vec_d & !hz & !branch_taken_e:
  - Issue lane 0: vec_active=1, vec_lane=0, de_en=1, pcWrEn=0, fd_en=0.
  - Next state VEC, cnt←1.
- VEC: vec_active=1, vec_lane=cnt, de_en=1.
  - If cnt<LANES-1: pcWrEn=0, fd_en=0, cnt←cnt+1.
  - If cnt==LANES-1 (last lane): pcWrEn=1, fd_en=1, next RUN, cnt←0.
  - Hazard inputs are ignored in VEC.
- Branch: branch_taken_e=1 in any state overrides everything:
  - pc_sel=1, newPc=branch_target_e, pcWrEn=1, fd_flush=1, de_flush=1, vec_active=0.
  - Next state RUN, cnt←0; an in-progress vector sequence is aborted.
- Priority: branch > load-use hazard > vector start/continue > default.
- stall_cycles increments when pcWrEn=0 and rst=0, and saturates at 16'hFFFF.

## Timing
- Reset (async assert): mode=RUN, cnt=0, stall_cycles=0. While rst=1, outputs are forced to: pcWrEn=0, pc_sel=0, newPc=0, fd_en=0, de_en=0, fd_flush=0, de_flush=0, vec_lane=0, vec_active=0.
- After rst deasserts, the first rising edge operates in RUN.
- Reset mid-vector: the sequence is dropped; no lane resumes after reset.
- Hazard and branch responses are same-cycle (combinational, zero latency).
- A vector instruction occupies decode for exactly LANES cycles, issues lanes 0..LANES-1 on consecutive cycles, and stalls fetch for LANES-1 cycles.
- Back-to-back vector instructions: the second is detected in RUN on the cycle after the last lane and starts immediately.
- Hazard and vector start in the same cycle: the stall wins; the vector starts on the first non-hazard cycle.

## Test plan
- Reset: assert rst mid-VEC at cnt=2 → outputs take their reset values immediately; after release, mode=RUN, vec_active=0, stall_cycles=0.
- Load-use: mem_read_e=1, reg_write_e=1, rd_e=5; decode uses_rs2_d=1, rs2_d=5 → one cycle of pcWrEn=0, fd_en=0, de_flush=1; stall_cycles=1; with rs2_d=6 instead → no stall.
- Vector (LANES=4): is_vec_d=1 in RUN → vec_lane 0,1,2,3 on consecutive cycles; pcWrEn=0 for 3 cycles, then 1 on lane 3; stall_cycles=3.
- Branch abort: branch_taken_e=1, branch_target_e=8'h3C at VEC cnt=2 → same cycle pc_sel=1, newPc=8'h3C, fd_flush=de_flush=1; next cycle RUN, cnt=0.
- Priority: hz=1, is_vec_d=1 and branch_taken_e=1 in the same cycle → branch response only; no bubble-only stall, no vector start.
- Saturation: force 70000 stall cycles → stall_cycles holds 16'hFFFF.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: load-use stalls, branch flushes and
// lane-by-lane issue of vector instructions held in decode.
module pipeline_ctrl #(
    parameter int LANES = 4,
    parameter int REG_W = 4,
    parameter int PC_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_valid_d,
    input  logic                     is_vec_d,
    input  logic [REG_W-1:0]         rs1_d,
    input  logic [REG_W-1:0]         rs2_d,
    input  logic                     uses_rs1_d,
    input  logic                     uses_rs2_d,
    input  logic                     mem_read_e,
    input  logic                     reg_write_e,
    input  logic [REG_W-1:0]         rd_e,
    input  logic                     branch_taken_e,
    input  logic [PC_W-1:0]          branch_target_e,
    output logic                     pcWrEn,
    output logic                     pc_sel,
    output logic [PC_W-1:0]          newPc,
    output logic                     fd_en,
    output logic                     de_en,
    output logic                     fd_flush,
    output logic                     de_flush,
    output logic [$clog2(LANES)-1:0] vec_lane,
    output logic                     vec_active,
    output logic [15:0]              stall_cycles
);

    localparam int LW = $clog2(LANES);
    localparam logic [LW-1:0] LAST = LW'(LANES - 1);

    typedef enum logic {RUN, VEC} mode_t;

    mode_t          mode_q, mode_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic [15:0]    stall_q, stall_d;
    logic           hz;

    assign hz = instr_valid_d & mem_read_e & reg_write_e &
                ((uses_rs1_d & (rs1_d == rd_e)) |
                 (uses_rs2_d & (rs2_d == rd_e)));

    always_comb begin
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        pcWrEn     = 1'b1;
        pc_sel     = 1'b0;
        newPc      = '0;
        fd_en      = 1'b1;
        de_en      = 1'b1;
        fd_flush   = 1'b0;
        de_flush   = 1'b0;
        vec_lane   = '0;
        vec_active = 1'b0;
        if (rst) begin
            pcWrEn = 1'b0;
            fd_en  = 1'b0;
            de_en  = 1'b0;
        end else if (branch_taken_e) begin
            pc_sel   = 1'b1;
            newPc    = branch_target_e;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            mode_d   = RUN;
            cnt_d    = '0;
        end else if (mode_q == VEC) begin
            // Hazard inputs are ignored while lanes are issuing.
            vec_active = 1'b1;
            vec_lane   = cnt_q;
            if (cnt_q == LAST) begin
                mode_d = RUN;
                cnt_d  = '0;
            end else begin
                pcWrEn = 1'b0;
                fd_en  = 1'b0;
                cnt_d  = cnt_q + LW'(1);
            end
        end else if (hz) begin
            pcWrEn   = 1'b0;
            fd_en    = 1'b0;
            de_flush = 1'b1;
        end else if (instr_valid_d & is_vec_d) begin
            vec_active = 1'b1;
            pcWrEn     = 1'b0;
            fd_en      = 1'b0;
            mode_d     = VEC;
            cnt_d      = LW'(1);
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pcWrEn && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl against an in-bench behavioural model,
// plus directed scenarios with literal expectations.
module tb_pipeline_ctrl;

    localparam int LANES = 4;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_valid_d, is_vec_d;
    logic [3:0]    rs1_d, rs2_d, rd_e;
    logic          uses_rs1_d, uses_rs2_d;
    logic          mem_read_e, reg_write_e, branch_taken_e;
    logic [7:0]    branch_target_e;
    logic          pcWrEn, pc_sel, fd_en, de_en, fd_flush, de_flush;
    logic [7:0]    newPc;
    logic [LW-1:0] vec_lane;
    logic          vec_active;
    logic [15:0]   stall_cycles;

    int errors = 0;
    int checks = 0;
    int cyc_n = 0;

    // Model state: lanes still owed by a vector in decode, next lane index.
    int m_left = 0;
    int m_lane = 0;
    int m_stall = 0;

    pipeline_ctrl #(.LANES(LANES), .REG_W(4), .PC_W(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid_d(instr_valid_d), .is_vec_d(is_vec_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d),
        .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d),
        .mem_read_e(mem_read_e), .reg_write_e(reg_write_e), .rd_e(rd_e),
        .branch_taken_e(branch_taken_e), .branch_target_e(branch_target_e),
        .pcWrEn(pcWrEn), .pc_sel(pc_sel), .newPc(newPc),
        .fd_en(fd_en), .de_en(de_en),
        .fd_flush(fd_flush), .de_flush(de_flush),
        .vec_lane(vec_lane), .vec_active(vec_active),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h",
                     name, cyc_n, act, exp);
        end
    endtask

    task automatic clear();
        instr_valid_d = 0; is_vec_d = 0;
        rs1_d = 0; rs2_d = 0; rd_e = 0;
        uses_rs1_d = 0; uses_rs2_d = 0;
        mem_read_e = 0; reg_write_e = 0;
        branch_taken_e = 0; branch_target_e = 0;
    endtask

    // Settle, compare all outputs with the model, then advance the model
    // across the coming rising edge.
    task automatic step();
        logic e_pw, e_ps, e_fe, e_de, e_ff, e_df, e_va;
        logic [7:0] e_np;
        logic [LW-1:0] e_ln;
        logic [15:0] e_st;
        bit hz;
        #1;
        hz = instr_valid_d && mem_read_e && reg_write_e &&
             ((uses_rs1_d && rs1_d == rd_e) ||
              (uses_rs2_d && rs2_d == rd_e));
        e_pw = 1; e_ps = 0; e_np = 0; e_fe = 1; e_de = 1;
        e_ff = 0; e_df = 0; e_va = 0; e_ln = 0;
        if (rst) begin
            e_pw = 0; e_fe = 0; e_de = 0;
            m_left = 0; m_lane = 0; m_stall = 0;
        end else if (branch_taken_e) begin
            e_ps = 1; e_np = branch_target_e;
            e_ff = 1; e_df = 1;
            m_left = 0; m_lane = 0;
        end else if (m_left > 0) begin
            e_va = 1; e_ln = LW'(m_lane);
            m_left--; m_lane++;
            if (m_left > 0) begin
                e_pw = 0; e_fe = 0;
            end else begin
                m_lane = 0;
            end
        end else if (hz) begin
            e_pw = 0; e_fe = 0; e_df = 1;
        end else if (instr_valid_d && is_vec_d) begin
            e_va = 1; e_pw = 0; e_fe = 0;
            m_left = LANES - 1; m_lane = 1;
        end
        e_st = 16'(m_stall);
        chk("outs",
            {pcWrEn, pc_sel, newPc, fd_en, de_en, fd_flush, de_flush,
             vec_active, vec_lane, stall_cycles},
            {e_pw, e_ps, e_np, e_fe, e_de, e_ff, e_df, e_va, e_ln, e_st});
        if (!rst && !e_pw && m_stall < 65535)
            m_stall++;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic set_hz(logic [3:0] r2);
        instr_valid_d = 1; mem_read_e = 1; reg_write_e = 1;
        rd_e = 5; uses_rs2_d = 1; rs2_d = r2;
    endtask

    initial begin
        clear();
        rst = 1;
        @(negedge clk);
        step();
        chk("rst_pcWrEn", pcWrEn, 0);
        tick();
        rst = 0;

        // Load-use on rs2 then non-matching register
        set_hz(4'd5);
        step();
        chk("lu_pcWrEn", pcWrEn, 0);
        chk("lu_fd_en", fd_en, 0);
        chk("lu_de_flush", de_flush, 1);
        tick();
        set_hz(4'd6);
        step();
        chk("lu_nostall", pcWrEn, 1);
        chk("lu_count", stall_cycles, 16'd1);
        tick();

        // Full vector sequence
        clear();
        instr_valid_d = 1; is_vec_d = 1;
        for (int i = 0; i < LANES; i++) begin
            step();
            chk("vec_lane", vec_lane, i);
            chk("vec_pcWrEn", pcWrEn, (i == LANES - 1));
            tick();
        end
        is_vec_d = 0;
        step();
        chk("vec_done", vec_active, 0);
        chk("vec_count", stall_cycles, 16'd4);
        tick();

        // Branch abort at lane 2
        is_vec_d = 1;
        step(); tick();
        step(); tick();
        branch_taken_e = 1; branch_target_e = 8'h3C;
        step();
        chk("br_pc_sel", pc_sel, 1);
        chk("br_newPc", newPc, 8'h3C);
        chk("br_flush", {fd_flush, de_flush}, 2'b11);
        chk("br_vec", vec_active, 0);
        tick();
        clear();
        step();
        chk("br_run", {vec_active, pcWrEn}, 2'b01);
        tick();

        // Branch beats hazard and vector start
        set_hz(4'd5);
        is_vec_d = 1; branch_taken_e = 1; branch_target_e = 8'h55;
        step();
        chk("pri_resp", {pcWrEn, pc_sel, fd_en, vec_active}, 4'b1110);
        tick();
        clear();

        // Reset mid-vector at lane 2
        instr_valid_d = 1; is_vec_d = 1;
        step(); tick();
        step(); tick();
        rst = 1;
        #2;
        chk("rstv_outs", {pcWrEn, vec_active, de_en}, 3'b000);
        chk("rstv_cnt", stall_cycles, 16'd0);
        step(); tick();
        rst = 0; is_vec_d = 0;
        step();
        chk("rstv_run", {vec_active, pcWrEn}, 2'b01);
        chk("rstv_zero", stall_cycles, 16'd0);
        tick();

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            instr_valid_d = ($urandom_range(0, 7) != 0);
            is_vec_d = ($urandom_range(0, 3) == 0);
            rs1_d = 4'($urandom_range(0, 3));
            rs2_d = 4'($urandom_range(0, 3));
            rd_e = 4'($urandom_range(0, 3));
            uses_rs1_d = 1'($urandom);
            uses_rs2_d = 1'($urandom);
            mem_read_e = 1'($urandom);
            reg_write_e = ($urandom_range(0, 3) != 0);
            branch_taken_e = ($urandom_range(0, 9) == 0);
            branch_target_e = 8'($urandom);
            step();
            tick();
        end

        // Saturation: continuous hazard
        clear();
        rst = 1;
        step(); tick();
        rst = 0;
        set_hz(4'd5);
        for (int n = 0; n < 70000; n++) begin
            step();
            tick();
        end
        step();
        chk("sat_value", stall_cycles, 16'hFFFF);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
